// File: rtl/fib_job_ctrl_if.sv
// Job-stream and fib-core handshake bundle for fib_job_ctrl.
// out_timeout exists only when FIB_TIMEOUT_EN is defined.
interface fib_job_ctrl_if #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [INPUT_WIDTH-1:0]  in_n;
    logic                    out_valid;
    logic                    out_ready;
    logic [INPUT_WIDTH-1:0]  out_n;
    logic [OUTPUT_WIDTH-1:0] out_result;
    logic                    out_overflow;
`ifdef FIB_TIMEOUT_EN
    logic                    out_timeout;
`endif
    logic                    fib_go;
    logic [INPUT_WIDTH-1:0]  fib_n;
    logic                    fib_done;
    logic [OUTPUT_WIDTH-1:0] fib_result;
    logic                    fib_overflow;

    modport slave (
        input  in_valid, in_n, out_ready, fib_done, fib_result, fib_overflow,
        output in_ready, out_valid, out_n, out_result, out_overflow, fib_go, fib_n
`ifdef FIB_TIMEOUT_EN
        , output out_timeout
`endif
    );

    modport master (
        output in_valid, in_n, out_ready, fib_done, fib_result, fib_overflow,
        input  in_ready, out_valid, out_n, out_result, out_overflow, fib_go, fib_n
`ifdef FIB_TIMEOUT_EN
        , input out_timeout
`endif
    );
endinterface

// File: rtl/fib_job_ctrl.sv
// Job controller in front of the fib core: input FIFO, one-job-at-a-time launch,
// tagged result register. Optional watchdog enabled by FIB_TIMEOUT_EN.
module fib_job_ctrl #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 16,
    parameter int DEPTH        = 4,
    parameter int TIMEOUT      = 1024
) (
    input logic           clk,
    input logic           rst_n,
    fib_job_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("fib_job_ctrl: DEPTH must be a power of two >= 2, TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {IDLE, GO, ARM, BUSY} state_t;

    state_t                 state, state_nxt;
    logic [INPUT_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic                   push, pop, empty, full_nxt, complete;

    assign push     = bus.in_valid && bus.in_ready;
    assign empty    = (wr_ptr == rd_ptr);
    assign wr_nxt   = wr_ptr + {{AW{1'b0}}, push};
    assign rd_nxt   = rd_ptr + {{AW{1'b0}}, pop};
    assign full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.in_n;
    end

    // in_ready is the registered complement of the post-update full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.in_ready <= 1'b0;
        end else begin
            wr_ptr       <= wr_nxt;
            rd_ptr       <= rd_nxt;
            bus.in_ready <= !full_nxt;
        end
    end

`ifdef FIB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit, timed_out;

    // the TIMEOUT-th cycle spent in ARM/BUSY ends the job
    assign tmo_hit = (state == ARM || state == BUSY) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            tmo_cnt <= '0;
        else if (pop)                          tmo_cnt <= '0;
        else if (state == ARM || state == BUSY) tmo_cnt <= tmo_cnt + CW'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        complete  = 1'b0;
`ifdef FIB_TIMEOUT_EN
        timed_out = 1'b0;
`endif
        case (state)
            IDLE: if (!empty && !bus.out_valid) begin
                pop       = 1'b1;
                state_nxt = GO;
            end
            GO:   state_nxt = ARM;
            // done may still be high from the previous job; wait for it to drop
            ARM:  if (!bus.fib_done) state_nxt = BUSY;
            BUSY: if (bus.fib_done) begin
                complete  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
`ifdef FIB_TIMEOUT_EN
        if (tmo_hit && !complete) begin
            complete  = 1'b1;
            timed_out = 1'b1;
            state_nxt = IDLE;
        end
`endif
    end

    assign bus.fib_go = (state == GO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.fib_n <= '0;
        else if (pop) bus.fib_n <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_n        <= '0;
            bus.out_result   <= '0;
            bus.out_overflow <= 1'b0;
`ifdef FIB_TIMEOUT_EN
            bus.out_timeout  <= 1'b0;
`endif
        end else if (complete) begin
            bus.out_valid    <= 1'b1;
            bus.out_n        <= bus.fib_n;
`ifdef FIB_TIMEOUT_EN
            bus.out_result   <= timed_out ? '0 : bus.fib_result;
            bus.out_overflow <= timed_out ? 1'b0 : bus.fib_overflow;
            bus.out_timeout  <= timed_out;
`else
            bus.out_result   <= bus.fib_result;
            bus.out_overflow <= bus.fib_overflow;
`endif
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fib_job_ctrl.sv
// Directed bench for fib_job_ctrl with a behavioural fib core that drops done
// one cycle late, so stale-done handling is exercised on every job.
module tb_fib_job_ctrl;
`ifdef FIB_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 1024;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   go_cnt = 0;
    int   core_lat;
    bit   core_hang;
`ifdef FIB_TIMEOUT_EN
    int   exp_to = 0;
`endif

    fib_job_ctrl_if #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(16)) bus ();

    fib_job_ctrl #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(16), .DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fib_go) go_cnt <= go_cnt + 1;
    end

    function automatic logic [16:0] fib_ref(input logic [5:0] n);
        longint a = 0, b = 1, t;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b; a = b; b = t;
        end
        return {(a > 65535), a[15:0]};
    endfunction

    logic [5:0] core_n;
    int         core_cnt;
    logic       core_run, drop_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fib_done <= 1'b0; bus.fib_result <= '0; bus.fib_overflow <= 1'b0;
            core_n <= '0; core_cnt <= 0; core_run <= 1'b0; drop_pend <= 1'b0;
        end else begin
            drop_pend <= 1'b0;
            if (drop_pend) bus.fib_done <= 1'b0;
            if (bus.fib_go) begin
                core_n <= bus.fib_n; core_cnt <= core_lat; core_run <= 1'b1; drop_pend <= 1'b1;
            end else if (core_run && !core_hang) begin
                if (core_cnt == 0) begin
                    bus.fib_done <= 1'b1;
                    {bus.fib_overflow, bus.fib_result} <= fib_ref(core_n);
                    core_run <= 1'b0;
                end else core_cnt <= core_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int n);
        int k = 0;
        while (!bus.in_ready && k < 200) begin @(negedge clk); k++; end
        chk("push_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.in_n = 6'(n);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int n, input int res, input int ovf);
        int k = 0;
        while (!bus.out_valid && k < 2000) begin @(negedge clk); k++; end
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_n"}, 32'(bus.out_n), n);
        chk({tag, "_res"}, 32'(bus.out_result), res);
        chk({tag, "_ovf"}, 32'(bus.out_overflow), ovf);
`ifdef FIB_TIMEOUT_EN
        chk({tag, "_to"}, 32'(bus.out_timeout), exp_to);
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, snap;
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_n = '0; bus.out_ready = 1'b0;
        core_lat = 3; core_hang = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_fib_go", 32'(bus.fib_go), 0);
        chk("rst_fib_n", 32'(bus.fib_n), 0);
        chk("rst_out_fields", {bus.out_overflow, bus.out_n, bus.out_result}, 0);
        rst_n = 1'b1;
        #1 chk("rel_in_ready_low", 32'(bus.in_ready), 0);
        @(negedge clk);
        chk("rel_in_ready_high", 32'(bus.in_ready), 1);

        // single job with launch latency and output timing
        push(10);
        chk("go_t1", 32'(bus.fib_go), 0);
        @(negedge clk);
        chk("go_t2", 32'(bus.fib_go), 1);
        chk("go_n", 32'(bus.fib_n), 10);
        @(negedge clk);
        chk("go_t3", 32'(bus.fib_go), 0);
        k = 0;
        while (!bus.fib_done && k < 100) begin @(negedge clk); k++; end
        chk("single_done_seen", 32'(bus.fib_done), 1);
        chk("single_ov_pre", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("single_ov_post", 32'(bus.out_valid), 1);
        collect("single", 10, 55, 0);

        // backpressure: 4 queued + 1 held, then drain in order
        for (int n = 1; n <= 5; n++) push(n);
        chk("bp_full", 32'(bus.in_ready), 0);
        repeat (10) @(negedge clk);
        chk("bp_still_full", 32'(bus.in_ready), 0);
        chk("bp_held_valid", 32'(bus.out_valid), 1);
        chk("bp_held_n", 32'(bus.out_n), 1);
        collect("bp1", 1, 1, 0);
        push(6);
        collect("bp2", 2, 1, 0);
        collect("bp3", 3, 2, 0);
        collect("bp4", 4, 3, 0);
        collect("bp5", 5, 5, 0);
        collect("bp6", 6, 8, 0);

        // overflow passes the core's truncated value through untouched
        push(40);
        collect("ovf", 40, 32459, 1);

        // stale done: B launches while done from A is still high
        push(5);
        k = 0;
        while (!bus.out_valid && k < 100) begin @(negedge clk); k++; end
        push(7);
        chk("stale_done_high", 32'(bus.fib_done), 1);
        collect("stale_a", 5, 5, 0);
        collect("stale_b", 7, 13, 0);

        // reset while BUSY with three jobs queued
        core_lat = 30;
        push(11); push(12); push(13); push(14);
        repeat (4) @(negedge clk);
        chk("prerst_in_ready", 32'(bus.in_ready), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_fib_go", 32'(bus.fib_go), 0);
        core_lat = 3;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rel_in_ready_low", 32'(bus.in_ready), 0);
        @(negedge clk);
        chk("mid_rel_in_ready_high", 32'(bus.in_ready), 1);
        snap = go_cnt;
        repeat (10) @(negedge clk);
        chk("post_rst_no_launch", 32'(go_cnt - snap), 0);
        chk("post_rst_no_out", 32'(bus.out_valid), 0);
        push(7);
        collect("post_rst", 7, 13, 0);

`ifdef FIB_TIMEOUT_EN
        // watchdog: core never answers, then a normal job follows
        begin
            int g, lat;
            core_hang = 1'b1;
            push(9);
            k = 0;
            while (!bus.fib_go && k < 20) begin @(negedge clk); k++; end
            chk("tmo_go", 32'(bus.fib_go), 1);
            g = cyc;
            k = 0;
            while (!bus.out_valid && k < 200) begin @(negedge clk); k++; end
            lat = cyc - g;
            chk("tmo_latency", 32'(lat >= TMO && lat <= TMO + 2), 1);
            exp_to = 1;
            collect("tmo", 9, 0, 0);
            core_hang = 1'b0;
            exp_to = 0;
            push(6);
            collect("tmo_next", 6, 8, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
